// File: rtl/mixcolumns_engine.sv
// AES MixColumns / InvMixColumns engine.
// A 128-bit state is buffered on acceptance, transformed LANES columns per
// cycle in place, then held on the output until the downstream handshake.
module mixcolumns_engine #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned N  = 4 / LANES;
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("mixcolumns_engine: LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grp_q, grp_d;
    logic [127:0]    buf_q, buf_d;
    logic            mode_q, mode_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [31:0]     cols     [4];
    logic [31:0]     ncol     [4];
    logic [1:0]      col_idx  [LANES];
    logic [31:0]     col_in   [LANES];
    logic [31:0]     col_fwd  [LANES];
    logic [31:0]     col_inv  [LANES];
    logic [31:0]     col_out  [LANES];
    logic [127:0]    buf_busy;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_mix(input logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] m2 [4];
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            m2[i] = xt(a[i]);
        end
        for (int r = 0; r < 4; r++) begin
            o[31-8*r -: 8] = m2[r] ^ (m2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        for (int r = 0; r < 4; r++) begin
            o[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        end
        return o;
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_cols
        assign cols[c] = buf_q[127-32*c -: 32];
    end

    // One column unit per lane; both modes computed, mode_q picks the result.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        if (N == 1) begin : g_fixed
            assign col_idx[l] = 2'(l);
        end else begin : g_mux
            assign col_idx[l] = 2'(32'(grp_q) * LANES + 32'(l));
        end
        assign col_in[l]  = cols[col_idx[l]];
        assign col_fwd[l] = fwd_mix(col_in[l]);
        assign col_inv[l] = inv_mix(col_in[l]);
        assign col_out[l] = mode_q ? col_inv[l] : col_fwd[l];
    end

    // Write the transformed group back into its column slots.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            ncol[c] = cols[c];
        end
        for (int l = 0; l < LANES; l++) begin
            ncol[col_idx[l]] = col_out[l];
        end
        buf_busy = {ncol[0], ncol[1], ncol[2], ncol[3]};
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        buf_d   = buf_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    buf_d   = in_state;
                    mode_d  = in_inv;
                    grp_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                buf_d = buf_busy;
                if (grp_q == GW'(N - 1)) begin
                    grp_d   = '0;
                    state_d = StDone;
                end else begin
                    grp_d = grp_q + GW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
        busy_d      = (state_d == StBusy) || (state_d == StDone);
    end

    // State and output registers; reset discards any in-flight block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grp_q       <= '0;
            buf_q       <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            buf_q       <= buf_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    // Partial results in the buffer are never exposed.
    assign out_state = out_valid_q ? buf_q : '0;

endmodule

// File: tb/tb_mixcolumns_engine.sv
// Directed and round-trip bench for mixcolumns_engine at LANES = 4, 2 and 1.
module tb_mixcolumns_engine;

    localparam logic [127:0] VecPlain = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] VecMixed = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] VecLatIn = 128'hc6c6c6c6_d4d4d4d5_01010101_2d26314c;
    localparam logic [127:0] VecLatEx = 128'hc6c6c6c6_d5d5d7d6_01010101_4d7ebdf8;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         in_inv    [3];
    logic [127:0] in_state  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic         busy      [3];

    int n_checks = 0;
    int n_errors = 0;

    mixcolumns_engine #(.LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_inv(in_inv[0]), .in_state(in_state[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0])
    );
    mixcolumns_engine #(.LANES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_inv(in_inv[1]), .in_state(in_state[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1])
    );
    mixcolumns_engine #(.LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_inv(in_inv[2]), .in_state(in_state[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_state(out_state[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lanes_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Push one block through engine d, optionally disturbing inputs while the
    // engine must ignore them, and hold the result for 'stall' cycles.
    task automatic run_block(input int d, input logic inv, input logic [127:0] st,
                             input int stall, input bit wiggle,
                             output logic [127:0] res);
        int w;
        int lat;
        w = 0;
        out_ready[d] = (stall == 0);
        while (!in_ready[d] && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check_val("in_ready_wait", 128'(in_ready[d]), 128'd1);
        in_valid[d] = 1'b1;
        in_inv[d]   = inv;
        in_state[d] = st;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        lat = 0;
        while (!out_valid[d] && lat < 20) begin
            check_val("in_ready_busy", 128'(in_ready[d]), 128'd0);
            check_val("busy_busy", 128'(busy[d]), 128'd1);
            if (wiggle) begin
                in_inv[d]   = ~in_inv[d];
                in_state[d] = rnd128();
                in_valid[d] = 1'b1;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid[d] = 1'b0;
        check_val("latency", 128'(lat), 128'(4 / lanes_of(d)));
        check_val("out_valid", 128'(out_valid[d]), 128'd1);
        check_val("in_ready_done", 128'(in_ready[d]), 128'd0);
        res = out_state[d];
        for (int s = 0; s < stall; s++) begin
            if (wiggle) begin
                in_valid[d] = ~in_valid[d];
                in_state[d] = rnd128();
            end
            @(posedge clk); #1;
            check_val("stall_state", out_state[d], res);
            check_val("stall_valid", 128'(out_valid[d]), 128'd1);
            check_val("stall_in_ready", 128'(in_ready[d]), 128'd0);
            check_val("stall_busy", 128'(busy[d]), 128'd1);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        check_val("released_valid", 128'(out_valid[d]), 128'd0);
        check_val("released_ready", 128'(in_ready[d]), 128'd1);
        check_val("released_busy", 128'(busy[d]), 128'd0);
    endtask

    initial begin
        logic [127:0] r1;
        logic [127:0] r2;
        logic [127:0] x;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_inv[d]    = 1'b0;
            in_state[d]  = '0;
            out_ready[d] = 1'b1;
        end

        // Reset values while rst_n is low.
        #12;
        for (int d = 0; d < 3; d++) begin
            check_val("rst_in_ready", 128'(in_ready[d]), 128'd0);
            check_val("rst_out_valid", 128'(out_valid[d]), 128'd0);
            check_val("rst_busy", 128'(busy[d]), 128'd0);
            check_val("rst_out_state", out_state[d], 128'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            check_val("post_rst_in_ready", 128'(in_ready[d]), 128'd1);
        end

        // Known forward and inverse vectors on every lane width.
        for (int d = 0; d < 3; d++) begin
            run_block(d, 1'b0, VecPlain, 0, 1'b0, r1);
            check_val("fwd_vec", r1, VecMixed);
            run_block(d, 1'b1, VecMixed, 0, 1'b0, r1);
            check_val("inv_vec", r1, VecPlain);
        end

        // Mode and state are latched at acceptance only.
        run_block(1, 1'b0, VecLatIn, 0, 1'b1, r1);
        check_val("mode_latch", r1, VecLatEx);

        // Backpressure: result held for 10 cycles with in_valid pulsing.
        run_block(0, 1'b0, VecPlain, 10, 1'b1, r1);
        check_val("backpressure", r1, VecMixed);

        // Reset in the middle of a LANES=1 block at grp = 2.
        in_valid[2] = 1'b1;
        in_inv[2]   = 1'b0;
        in_state[2] = VecPlain;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        check_val("mid_busy", 128'(busy[2]), 128'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_in_ready", 128'(in_ready[2]), 128'd0);
        check_val("mid_rst_out_valid", 128'(out_valid[2]), 128'd0);
        check_val("mid_rst_busy", 128'(busy[2]), 128'd0);
        check_val("mid_rst_out_state", out_state[2], 128'h0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("mid_rst_release", 128'(in_ready[2]), 128'd1);
        check_val("mid_rst_no_output", 128'(out_valid[2]), 128'd0);
        run_block(2, 1'b1, VecMixed, 0, 1'b0, r1);
        check_val("after_rst_vec", r1, VecPlain);

        // Random round trip with random output stalls.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 1000; i++) begin
                x = rnd128();
                run_block(d, 1'b0, x, int'($urandom_range(0, 2)), 1'b0, r1);
                run_block(d, 1'b1, r1, int'($urandom_range(0, 2)), 1'b0, r2);
                check_val("round_trip", r2, x);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mixcolumns_engine.md
# mixcolumns_engine

Multi-cycle, parametrised AES (Advanced Encryption Standard) MixColumns / InvMixColumns engine. It operates on a full 128-bit state and processes LANES columns per clock. The mode, forward or inverse, is selected per block. The engine sits between the ShiftRows and AddRoundKey stages of the round datapath and uses valid/ready handshakes on both sides so the round controller can stall it. It generalises the single-column combinational inverse mixer: one engine serves both cipher directions and trades area for latency.

## Interface
- LANES, default 4: columns transformed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream holds a valid block.
- in_ready  output  1  engine can accept a block.
- in_inv  input  1  mode, sampled only at acceptance: 0 = MixColumns, 1 = InvMixColumns.
- in_state  input  128  state, column-major. Byte s[r][c] = in_state[127-8*(4c+r) -: 8].
- out_valid  output  1  out_state holds a finished block.
- out_ready  input  1  downstream accepts the block.
- out_state  output  128  transformed state, same byte order as in_state.
- busy  output  1  high in BUSY or DONE.

## Operation
- N = 4/LANES compute cycles per block.
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid, register in_state into the 128-bit buffer and latch in_inv into mode_q.
  - Clear the group counter grp to 0 and go to BUSY.
- BUSY:
  - Transform columns grp*LANES to grp*LANES+LANES-1 of the buffer and write them back in place.
  - grp increments each cycle. When grp = N-1, go to DONE; grp wraps to 0.
  - in_ready = 0. Changes on in_inv and in_state are ignored.
- DONE:
  - out_valid = 1 and out_state = buffer.
  - On out_ready, go to IDLE. out_state holds its value until that handshake.
- Column math, GF(2^8) with polynomial 0x11B:
  - xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0x00).
  - Multiples 2, 3, 9, 0xB, 0xD and 0xE are built from xtime chains and XOR only; no lookup tables.
- Forward rows, input column a0..a3:
  - out_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
- Inverse rows:
  - out_r = E·a_r ^ B·a_(r+1) ^ D·a_(r+2) ^ 9·a_(r+3), indices mod 4.
- LANES column units are instantiated. Each unit computes both modes, and the output is selected by mode_q.
- Column mux for LANES < 4 is indexed by grp. For LANES = 4 there is no mux and grp is a constant 0.

## Timing
- Reset values: in_ready = 0 while rst_n = 0, then 1 in IDLE; out_valid = 0; busy = 0; out_state = 128'h0; buffer = 0; grp = 0; mode_q = 0.
- Acceptance happens on an edge where in_valid && in_ready.
- out_valid rises after edge E0+N, where E0 is the acceptance edge. Latency is 1, 2 or 4 cycles for LANES = 4, 2 or 1.
- Throughput is one block per N+2 cycles when out_ready is held high. in_ready is never high in the same cycle as out_valid.
- Output stall: if out_ready = 0, stay in DONE indefinitely. out_state and out_valid are stable, and no new block is accepted.
- Handshake rule: out_valid never drops without an out_ready handshake.
- Reset mid-operation: asserting rst_n low in any state immediately forces IDLE and the reset output values. The in-flight block is discarded and no partial result is ever presented.
- in_valid may drop without a handshake in IDLE; this has no effect.
- in_ready and out_valid are pure state decodes. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Forward, LANES = 4:
  - in_state = db135345_f20a225c_01010101_2d26314c, in_inv = 0.
  - out_state = 8e4da1bc_9fdc589d_01010101_4d7ebdf8.
  - out_valid high 1 cycle after acceptance.
- Inverse, LANES = 1:
  - in_state = 8e4da1bc_9fdc589d_01010101_4d7ebdf8, in_inv = 1.
  - out_state = db135345_f20a225c_01010101_2d26314c.
  - out_valid high 4 cycles after acceptance; in_ready low for those cycles.
- Mode latch, LANES = 2:
  - Accept c6c6c6c6_d4d4d4d5_… with in_inv = 0, then toggle in_inv and in_state during BUSY.
  - Column 1 is d5d5d7d6 and column 0 is c6c6c6c6, unaffected by the toggling.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid.
  - out_state is stable, in_ready = 0 and busy = 1; in_valid pulses are ignored.
  - Raising out_ready returns the engine to IDLE on the next edge.
- Reset mid-block:
  - Drop rst_n during BUSY (LANES = 1, grp = 2).
  - All outputs are 0 immediately. After release, in_ready = 1 and the next block's result is correct.
- Randomised round-trip for every LANES value:
  - Inverse(forward(x)) = x for 1000 random states.
  - Random out_ready stalls; no lost or duplicated blocks.
